// File: rtl/vga_fill_ctrl.sv
// vga_fill_ctrl: Avalon-MM programmable rectangle filler for a 160x120, 8-bit
// colour pixel plotter. Software programs two corners and a colour, starts the
// fill, and the block streams one packed pixel per accepted master write.
module vga_fill_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [3:0]  vga_address,
  output logic        vga_write,
  output logic [31:0] vga_writedata,
  input  logic        vga_waitrequest,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLOT   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Pack one pixel into the plotter word layout
  function automatic logic [31:0] pack_pixel(input logic [7:0] x,
                                             input logic [6:0] y,
                                             input logic [7:0] c);
    return {1'b0, y, x, 8'h00, c};
  endfunction

  state_t      state_r;
  logic        busy_r;
  logic        done_r;
  logic [7:0]  p0_x_r;
  logic [6:0]  p0_y_r;
  logic [7:0]  p1_x_r;
  logic [6:0]  p1_y_r;
  logic [7:0]  colour_r;
  logic [7:0]  sh_x0_r;
  logic [7:0]  sh_x1c_r;
  logic [6:0]  sh_y1c_r;
  logic [7:0]  sh_colour_r;
  logic [7:0]  cur_x_r;
  logic [6:0]  cur_y_r;

  logic        ctrl_wr_s;
  logic        start_s;
  logic        clear_s;
  logic [7:0]  x1c_s;
  logic [6:0]  y1c_s;
  logic        empty_s;
  logic        row_end_s;
  logic        last_s;
  logic [7:0]  next_x_s;
  logic [6:0]  next_y_s;
  logic        unused_s;

  // Only bits that carry a field are decoded; the rest are reserved.
  assign unused_s    = ^{writedata[31], writedata[15:8]};
  assign vga_address = 4'd0;
  assign irq         = done_r;

  // Command decode, start-time clamping and raster-advance arithmetic
  always_comb begin
    ctrl_wr_s = write && (address == 4'd0);
    start_s   = ctrl_wr_s && writedata[0] && (state_r == IDLE);
    clear_s   = ctrl_wr_s && (writedata[1] || start_s);
    x1c_s     = (p1_x_r > 8'd159) ? 8'd159 : p1_x_r;
    y1c_s     = (p1_y_r > 7'd119) ? 7'd119 : p1_y_r;
    empty_s   = (p0_x_r > x1c_s) || (p0_y_r > y1c_s);
    row_end_s = (cur_x_r == sh_x1c_r);
    last_s    = row_end_s && (cur_y_r == sh_y1c_r);
    if (row_end_s) begin
      next_x_s = sh_x0_r;
      next_y_s = cur_y_r + 7'd1;
    end else begin
      next_x_s = cur_x_r + 8'd1;
      next_y_s = cur_y_r;
    end
  end

  // Zero-latency register readback; unmapped addresses read as zero
  always_comb begin
    readdata = 32'd0;
    if (read) begin
      case (address)
        4'd0:    readdata = {30'd0, done_r, busy_r};
        4'd1:    readdata = {1'b0, p0_y_r, p0_x_r, 16'd0};
        4'd2:    readdata = {1'b0, p1_y_r, p1_x_r, 16'd0};
        4'd3:    readdata = {24'd0, colour_r};
        default: readdata = 32'd0;
      endcase
    end else begin
      readdata = 32'd0;
    end
  end

  // Software-visible corner and colour registers, writable at any time
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p0_x_r   <= 8'd0;
      p0_y_r   <= 7'd0;
      p1_x_r   <= 8'd0;
      p1_y_r   <= 7'd0;
      colour_r <= 8'd0;
    end else if (write) begin
      case (address)
        4'd1: begin
          p0_x_r <= writedata[23:16];
          p0_y_r <= writedata[30:24];
        end
        4'd2: begin
          p1_x_r <= writedata[23:16];
          p1_y_r <= writedata[30:24];
        end
        4'd3:    colour_r <= writedata[7:0];
        default: ;
      endcase
    end
  end

  // Sticky completion flag; completion beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_r <= 1'b0;
    end else if (state_r == FINISH) begin
      done_r <= 1'b1;
    end else if (clear_s) begin
      done_r <= 1'b0;
    end
  end

  // Fill sequencer: snapshots the job at start and streams pixels in raster order
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      busy_r        <= 1'b0;
      vga_write     <= 1'b0;
      vga_writedata <= 32'd0;
      sh_x0_r       <= 8'd0;
      sh_x1c_r      <= 8'd0;
      sh_y1c_r      <= 7'd0;
      sh_colour_r   <= 8'd0;
      cur_x_r       <= 8'd0;
      cur_y_r       <= 7'd0;
    end else begin
      case (state_r)
        IDLE: begin
          vga_write <= 1'b0;
          if (start_s) begin
            sh_x0_r     <= p0_x_r;
            sh_x1c_r    <= x1c_s;
            sh_y1c_r    <= y1c_s;
            sh_colour_r <= colour_r;
            cur_x_r     <= p0_x_r;
            cur_y_r     <= p0_y_r;
            busy_r      <= 1'b1;
            if (empty_s) begin
              state_r <= FINISH;
            end else begin
              state_r       <= PLOT;
              vga_write     <= 1'b1;
              vga_writedata <= pack_pixel(p0_x_r, p0_y_r, colour_r);
            end
          end
        end
        PLOT: begin
          // Outputs are held untouched while the plotter stalls.
          if (!vga_waitrequest) begin
            if (last_s) begin
              state_r   <= FINISH;
              vga_write <= 1'b0;
            end else begin
              cur_x_r       <= next_x_s;
              cur_y_r       <= next_y_s;
              vga_writedata <= pack_pixel(next_x_s, next_y_s, sh_colour_r);
            end
          end
        end
        FINISH: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          vga_write <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          vga_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
